// File: rtl/encoder_scan_if.sv
// Handshake bundle for encoder_scan: input vector stream and index output stream.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control of each stream.
interface encoder_scan_if #(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = $clog2(IN_SIZE)
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_SIZE-1:0]  in;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_SIZE-1:0] pow;
  logic                out_last;

  // Block side: consumes vectors, produces indices.
  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, pow, out_last
  );

  // Environment side: produces vectors, consumes indices.
  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, pow, out_last
  );
endinterface

// File: rtl/encoder_scan.sv
// Sequential multi-hot to binary encoder: emits the index of every set bit, one per beat.
// Latency: vector accepted at edge N, first index valid in cycle N+1; one index per cycle.
// Backpressure: out_ready low holds pow/out_last/pend; in_ready only while idle.
// Order is LSB-first; define ENCODER_SCAN_MSB_FIRST_EN for MSB-first.
module encoder_scan #(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = $clog2(IN_SIZE)
) (
  input logic           clk,
  input logic           rst,
  encoder_scan_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              r_state;
  logic [IN_SIZE-1:0]  r_pend;
  logic [OUT_SIZE-1:0] r_pow;
  logic                r_last;
  logic                r_valid;
  logic                r_in_ready;

  logic                w_take;
  logic                w_beat;
  logic [IN_SIZE-1:0]  w_clr;
  logic [IN_SIZE-1:0]  w_pend_nxt;

  // Priority encoder selecting the next index to emit; only indices below
  // IN_SIZE are ever produced, so non-power-of-2 widths stay in range.
  function automatic logic [OUT_SIZE-1:0] f_enc(input logic [IN_SIZE-1:0] v);
    logic [OUT_SIZE-1:0] idx;
    idx = '0;
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    for (int i = 0; i < IN_SIZE; i++) begin
      if (v[i]) idx = OUT_SIZE'(i);
    end
`else
    for (int i = IN_SIZE - 1; i >= 0; i--) begin
      if (v[i]) idx = OUT_SIZE'(i);
    end
`endif
    return idx;
  endfunction

  // A zero vector is swallowed in IDLE without ever entering SCAN.
  assign w_take = r_in_ready && bus.in_valid && (bus.in != '0);
  assign w_beat = r_valid && bus.out_ready;

  // Pending vector with the currently presented bit removed.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (OUT_SIZE'(i) == r_pow) w_clr[i] = 1'b1;
    end
    w_pend_nxt = r_pend & ~w_clr;
  end

  // Scan FSM; all outputs are registered so nothing on the input side
  // reaches the output ports combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_pow      <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_pend     <= bus.in;
            r_pow      <= f_enc(bus.in);
            r_last     <= $onehot(bus.in);
            r_valid    <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_beat) begin
            r_pend <= w_pend_nxt;
            if (r_last) begin
              r_pow      <= '0;
              r_last     <= 1'b0;
              r_valid    <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_pow  <= f_enc(w_pend_nxt);
              r_last <= $onehot(w_pend_nxt);
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.pow       = r_pow;
  assign bus.out_last  = r_last;

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan with a beat scoreboard.
// Latency: first beat expected one cycle after vector acceptance.
// Backpressure: exercised by holding out_ready low mid-vector.
module tb_encoder_scan;

  typedef struct packed {
    logic [2:0] pow;
    logic       last;
  } beat_t;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;
  beat_t exp_q[$];

  encoder_scan_if #(.IN_SIZE(8), .OUT_SIZE(3)) bus ();

  encoder_scan #(.IN_SIZE(8), .OUT_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference order of indices for one vector.
  task automatic push_exp(input logic [7:0] v);
    int    n;
    int    k;
    beat_t b;
    n = $countones(v);
    k = 0;
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) begin
`else
    for (int i = 0; i < 8; i++) begin
`endif
      if (v[i]) begin
        k++;
        b.pow  = 3'(i);
        b.last = (k == n);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 60), 32'd1);
  endtask

  // Drive one vector; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] v);
    wait_ready("send");
    bus.in       = v;
    bus.in_valid = 1'b1;
    push_exp(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: compare every transferred beat against the model.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed pow %0d expected no beat", bus.pow);
        end
      end else begin
        b = exp_q.pop_front();
        check("beat_pow", 32'(bus.pow), 32'(b.pow));
        check("beat_last", 32'(bus.out_last), 32'(b.last));
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;

    // 1. Reset state before any clock edge.
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pow", 32'(bus.pow), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2. Basic scan: four beats on consecutive cycles, then idle.
    bus.out_ready = 1'b1;
    send(8'b1010_0110);
    check("basic_busy", 32'(bus.in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("basic_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("basic_drained", 32'(exp_q.size()), 32'd0);

    // 3. Backpressure: first beat held for three cycles.
    bus.out_ready = 1'b0;
    send(8'b1010_0110);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_pow", 32'(bus.pow), 32'(exp_q[0].pow));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_ready("bp_done");
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // 4. Edge vectors.
    send(8'h00);
    check("zero_in_ready", 32'(bus.in_ready), 32'd1);
    check("zero_no_beat", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("zero_still_idle", 32'(bus.out_valid), 32'd0);
    send(8'h80);
    check("h80_pow", 32'(bus.pow), 32'd7);
    check("h80_last", 32'(bus.out_last), 32'd1);
    wait_ready("h80_done");
    send(8'hFF);
    wait_ready("hff_done");
    check("edge_drained", 32'(exp_q.size()), 32'd0);

    // 5. Reset after two beats have transferred.
    send(8'b1010_0110);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_pow", 32'(bus.pow), 32'd0);
    check("mid_rst_last", 32'(bus.out_last), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(8'h10);
    check("h10_pow", 32'(bus.pow), 32'd4);
    check("h10_last", 32'(bus.out_last), 32'd1);
    wait_ready("h10_done");

    // 6. Back-to-back vectors with in_valid held high.
    bus.in       = 8'h03;
    bus.in_valid = 1'b1;
    push_exp(8'h03);
    @(posedge clk);
    #1;
    bus.in = 8'h40;
    push_exp(8'h40);
    check("b2b_busy1", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_busy2", 32'(bus.in_ready), 32'd0);
    check("b2b_last1", 32'(bus.out_last), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2b_second_pow", 32'(bus.pow), 32'd6);
    wait_ready("b2b_done");
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
